rc_up_counter: RTL and testbench

RC_UP_COUNTER -- requirements
Module: rc_up_counter

---
 rtl/rc_up_counter.sv | 50 +++++
 tb/tb_rc_up_counter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rc_up_counter.sv
// Purpose : free-running WIDTH-bit binary up counter, next state built from a ripple-carry increment chain.
// Latency : one clock; q shows the incremented (or reset) value after the rising edge that samples it.
// Backpressure : none; there is no enable, so the counter advances on every clock edge.
//
// Ports:
//   clk   - single clock; every flip-flop updates on its rising edge only
//   reset - synchronous active-high reset; forces q to 0 at the edge, overriding the increment
//   q     - current count, driven straight from the state flops
module rc_up_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    // Only widths 2..16 are supported.
    if (WIDTH < 2 || WIDTH > 16) begin : g_width_check
        $error("rc_up_counter: WIDTH must be within 2..16");
    end

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             carry;

    // Ripple-carry increment, one slice per bit. The carry into slice 0 is
    // a constant 1, so each slice toggles when every lower bit is 1.
    // carry is reused as the running carry from one slice to the next.
    always_comb begin
        q_d   = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            q_d[i] = q_q[i] ^ carry;
            carry  = q_q[i] & carry;
        end
    end

    // All bits share clk, so there are no derived clocks. Reset takes
    // priority over the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_rc_up_counter.sv
module tb_rc_up_counter;

    logic       clk;
    logic       reset;
    logic [3:0] q4;
    logic [7:0] q8;

    int checks = 0;
    int errors = 0;

    rc_up_counter #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .q     (q4)
    );

    rc_up_counter #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .q     (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: count value as a plain integer, (prev+1) mod 2^W,
    // forced to 0 by reset. It becomes meaningful after the first reset edge.
    int  m4 = 0;
    int  m8 = 0;
    bit  mvalid = 1'b0;

    always @(posedge clk) begin
        logic r;
        r = reset;
        #1;
        if (r === 1'b1) begin
            m4 = 0;
            m8 = 0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            m4 = (m4 + 1) % 16;
            m8 = (m8 + 1) % 256;
        end
        if (mvalid) begin
            chk("model_w4", {28'b0, q4}, m4);
            chk("model_w8", {24'b0, q8}, m8);
        end
    end

    // Drive reset away from the edge, then return #1 after the next rising edge.
    task automatic tick(input logic rst);
        @(negedge clk);
        reset = rst;
        @(posedge clk);
        #1;
    endtask

    // Advance with reset low until q4 reaches target; an expired budget is a failure.
    task automatic run_to(input int target);
        int n;
        n = 0;
        while (q4 !== target[3:0] && n < 40) begin
            tick(1'b0);
            n++;
        end
        chk("run_to_reached", {28'b0, q4}, target);
    endtask

    int seq [20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 3, 4};

    initial begin
        reset = 1'b1;

        // First edge (t=5) with reset high.
        @(posedge clk);
        #1;
        chk("reset_edge_w4", {28'b0, q4}, 0);
        chk("reset_edge_w8", {24'b0, q8}, 0);

        // Release at t=10, then 20 free-running edges t=15..205.
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            chk("free_run", {28'b0, q4}, seq[i]);
        end
        chk("free_run_final", {28'b0, q4}, 4);
        chk("free_run_w8", {24'b0, q8}, 20);

        // Wrap-around: 14 -> 15 -> 0 -> 1.
        run_to(14);
        tick(1'b0);
        chk("wrap_15", {28'b0, q4}, 15);
        tick(1'b0);
        chk("wrap_0", {28'b0, q4}, 0);
        tick(1'b0);
        chk("wrap_1", {28'b0, q4}, 1);

        // Mid-count reset at q=9.
        run_to(9);
        tick(1'b1);
        chk("mid_reset", {28'b0, q4}, 0);
        tick(1'b0);
        chk("mid_release_1", {28'b0, q4}, 1);
        tick(1'b0);
        chk("mid_release_2", {28'b0, q4}, 2);

        // Reset while at the maximum value.
        run_to(15);
        tick(1'b1);
        chk("reset_at_max", {28'b0, q4}, 0);

        // Held reset for 5 edges, then release.
        for (int i = 0; i < 5; i++) begin
            tick(1'b1);
            chk("held_reset", {28'b0, q4}, 0);
        end
        tick(1'b0);
        chk("held_release", {28'b0, q4}, 1);

        // WIDTH=8: 256 edges after reset return to 0.
        tick(1'b1);
        chk("w8_reset", {24'b0, q8}, 0);
        for (int i = 0; i < 256; i++) begin
            tick(1'b0);
            if (i == 0) chk("w8_first", {24'b0, q8}, 1);
            if (i == 254) chk("w8_max", {24'b0, q8}, 255);
        end
        chk("w8_full_cycle", {24'b0, q8}, 0);
        chk("w4_full_cycle", {28'b0, q4}, 0);

        // Randomised reset pulses; the model process checks every edge.
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 7) == 0);
        end
        tick(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
